// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg: shared channel indices, board defaults and sizing helper
package tick_scheduler_pkg;
  localparam int CH_BALL   = 0;
  localparam int CH_PADDLE = 1;
  localparam int CH_BLINK  = 2;
  localparam int CH_UART   = 3;
  localparam int BOARD_CW  = 16;
  localparam int BOARD_PRE = 24;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..PRE-1 counter; base_tick on the terminal count
module tick_prescaler #(
  parameter int PRE = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic base_tick_o
);
  localparam int PW = $clog2(PRE);
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  assign base_tick_o = pre_cnt_q == PW'(PRE - 1);
  assign pre_cnt_d = (sync_i || base_tick_o) ? '0 : pre_cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) pre_cnt_q <= '0;
    else pre_cnt_q <= pre_cnt_d;
  end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: NCH programmable-period clock-enable channels sharing one prescaler
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CW         = 16,
  parameter int PRE        = 24,
  parameter int DEF_PERIOD = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [idx_w(NCH)-1:0]  cfg_ch_i,
  input  logic [CW-1:0]          cfg_period_i,
  output logic [NCH-1:0]         tick_o,
  output logic [NCH-1:0]         active_o
);
  localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);
  logic           base_tick, accept;
  logic           cfg_ready_q, cfg_ready_d;
  logic [NCH-1:0] tick_q, tick_d, active_q, active_d;
  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  tick_prescaler #(.PRE(PRE)) u_pre (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_i      (sync_i),
    .base_tick_o (base_tick)
  );
  assign accept      = cfg_valid_i && cfg_ready_q;
  assign cfg_ready_d = !accept;
  // Out-of-range channel indices never match a channel, so such writes are accepted as no-ops
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic wr, run, hit;
    assign wr          = accept && (int'(cfg_ch_i) == c);
    assign run         = base_tick && (period_q[c] != '0);
    assign hit         = run && (cnt_q[c] == period_q[c] - 1'b1);
    assign period_d[c] = wr ? cfg_period_i : period_q[c];
    assign cnt_d[c]    = (sync_i || wr || hit) ? '0 : run ? cnt_q[c] + 1'b1 : cnt_q[c];
    assign tick_d[c]   = hit && !sync_i && !wr;
    assign active_d[c] = period_q[c] != '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b1;
      tick_q      <= '0;
      active_q    <= {NCH{DEF_P != '0}};
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= DEF_P;
        cnt_q[i]    <= '0;
      end
    end else begin
      cfg_ready_q <= cfg_ready_d;
      tick_q      <= tick_d;
      active_q    <= active_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
    end
  end
  assign cfg_ready_o = cfg_ready_q;
  assign tick_o      = tick_q;
  assign active_o    = active_q;
endmodule
